// File: rtl/pong_pkg.sv
// Shared geometry, colours and ball FSM encoding for the pong display block.
package pong_pkg;

  localparam logic [9:0] H_ACTIVE   = 10'd640;
  localparam logic [9:0] V_ACTIVE   = 10'd480;

  localparam logic [9:0] BALL_SIZE  = 10'd8;
  localparam logic [9:0] BALL_X0    = 10'd316;
  localparam logic [9:0] BALL_Y0    = 10'd236;
  localparam logic [9:0] BALL_X_MAX = H_ACTIVE - BALL_SIZE;
  localparam logic [9:0] BALL_Y_MAX = V_ACTIVE - BALL_SIZE;

  localparam logic [9:0] PAD_W      = 10'd8;
  localparam logic [9:0] PAD_H      = 10'd72;
  localparam logic [9:0] PAD_L_X    = 10'd32;
  localparam logic [9:0] PAD_R_X    = 10'd600;
  localparam logic [9:0] PAD_INIT   = 10'd204;
  localparam logic [9:0] PAD_MAX    = V_ACTIVE - PAD_H;

  localparam logic [9:0] LINE_X0    = 10'd319;
  localparam logic [9:0] LINE_X1    = 10'd320;

  localparam logic [11:0] COL_BLACK = 12'h000;
  localparam logic [11:0] COL_BALL  = 12'hFFF;
  localparam logic [11:0] COL_PAD   = 12'h0F0;
  localparam logic [11:0] COL_LINE  = 12'h888;

  typedef enum logic [1:0] {
    ST_SERVE  = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORED = 2'd2
  } ball_state_e;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/pong_graphics_if.sv
// Pixel-stream signals from the video timing generator into the pong display.
interface pong_graphics_if;
  logic       p_tick;
  logic       video_on;
  logic [9:0] x;
  logic [9:0] y;

  modport master (output p_tick, video_on, x, y);
  modport slave  (input  p_tick, video_on, x, y);
endinterface

// File: rtl/pong_ball.sv
// Ball FSM: serve delay, motion with wall/paddle bounces, miss detection and BCD scoring.
module pong_ball
  import pong_pkg::*;
#(
  parameter int BALL_V        = 2,
  parameter int SERVE_FRAMES  = 60,
  parameter int SCORED_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick_i,
  input  logic [9:0] pl_i,
  input  logic [9:0] pr_i,
  output logic [9:0] bx_o,
  output logic [9:0] by_o,
  output logic       hidden_o,
  output logic [3:0] score_l_o,
  output logic [3:0] score_r_o
);

  localparam logic [9:0] BV          = 10'(BALL_V);
  localparam logic [7:0] SERVE_LAST  = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] SCORED_LAST = 8'(SCORED_FRAMES - 1);

  ball_state_e state_q;
  logic [9:0]  bx_q, by_q;
  logic        vx_neg_q, vy_neg_q;
  logic        serve_left_q;
  logic [7:0]  cnt_q;
  logic [3:0]  score_l_q, score_r_q;

  logic        rows_l, rows_r;
  logic        pad_l_hit, pad_r_hit, miss_l, miss_r, top_hit, bot_hit;
  logic [9:0]  bx_step, by_step;

  // All event tests look at the pre-move position so a bounce lands exactly on the edge.
  assign rows_l    = (by_q + BALL_SIZE > pl_i) && (by_q < pl_i + PAD_H);
  assign rows_r    = (by_q + BALL_SIZE > pr_i) && (by_q < pr_i + PAD_H);
  assign pad_l_hit = vx_neg_q && (bx_q >= PAD_L_X) && (bx_q <= PAD_L_X + PAD_W + BV) && rows_l;
  assign pad_r_hit = !vx_neg_q && (bx_q + BALL_SIZE >= PAD_R_X - BV)
                     && (bx_q + BALL_SIZE <= PAD_R_X + PAD_W) && rows_r;
  assign miss_l    = vx_neg_q && (bx_q < BV);
  assign miss_r    = !vx_neg_q && (bx_q >= BALL_X_MAX - BV);
  assign top_hit   = vy_neg_q && (by_q < BV);
  assign bot_hit   = !vy_neg_q && (by_q >= BALL_Y_MAX - BV);
  assign bx_step   = vx_neg_q ? bx_q - BV : bx_q + BV;
  assign by_step   = vy_neg_q ? by_q - BV : by_q + BV;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_SERVE;
      bx_q         <= BALL_X0;
      by_q         <= BALL_Y0;
      vx_neg_q     <= 1'b0;
      vy_neg_q     <= 1'b0;
      serve_left_q <= 1'b0;
      cnt_q        <= 8'd0;
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
    end else if (frame_tick_i) begin
      case (state_q)
        ST_SERVE: begin
          bx_q <= BALL_X0;
          by_q <= BALL_Y0;
          if (cnt_q == SERVE_LAST) begin
            state_q  <= ST_PLAY;
            cnt_q    <= 8'd0;
            vx_neg_q <= serve_left_q;
            vy_neg_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_PLAY: begin
          // A miss freezes the ball where it left the field; no bounce is applied.
          if (miss_l || miss_r) begin
            state_q      <= ST_SCORED;
            cnt_q        <= 8'd0;
            serve_left_q <= miss_l;
            if (miss_l) score_r_q <= bcd_inc(score_r_q);
            else        score_l_q <= bcd_inc(score_l_q);
          end else begin
            if (pad_l_hit) begin
              bx_q     <= PAD_L_X + PAD_W;
              vx_neg_q <= 1'b0;
            end else if (pad_r_hit) begin
              bx_q     <= PAD_R_X - BALL_SIZE;
              vx_neg_q <= 1'b1;
            end else begin
              bx_q <= bx_step;
            end
            if (top_hit) begin
              by_q     <= 10'd0;
              vy_neg_q <= 1'b0;
            end else if (bot_hit) begin
              by_q     <= BALL_Y_MAX;
              vy_neg_q <= 1'b1;
            end else begin
              by_q <= by_step;
            end
          end
        end
        ST_SCORED: begin
          if (cnt_q == SCORED_LAST) begin
            state_q <= ST_SERVE;
            cnt_q   <= 8'd0;
            bx_q    <= BALL_X0;
            by_q    <= BALL_Y0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_SERVE;
      endcase
    end
  end

  assign bx_o      = bx_q;
  assign by_o      = by_q;
  assign hidden_o  = (state_q == ST_SCORED);
  assign score_l_o = score_l_q;
  assign score_r_o = score_r_q;

endmodule

// File: rtl/pong_graphics.sv
// Pong display block: paddle control, ball sub-module and registered pixel colour mux.
module pong_graphics
  import pong_pkg::*;
#(
  parameter int PAD_V         = 4,
  parameter int BALL_V        = 2,
  parameter int SERVE_FRAMES  = 60,
  parameter int SCORED_FRAMES = 30
) (
  input  logic            clk,
  input  logic            reset,
  pong_graphics_if.slave  vid,
  input  logic            btn_up_l,
  input  logic            btn_dn_l,
  input  logic            btn_up_r,
  input  logic            btn_dn_r,
  output logic [11:0]     rgb,
  output logic [3:0]      score_l,
  output logic [3:0]      score_r
);

  localparam logic [9:0] PV = 10'(PAD_V);

  logic        frame_tick;
  logic [9:0]  pl_q, pl_d, pr_q, pr_d;
  logic [9:0]  bx, by;
  logic        hidden;
  logic        ball_on, padl_on, padr_on, line_on;
  logic [11:0] rgb_q, rgb_d;

  function automatic logic [9:0] pad_next(input logic [9:0] p, input logic up, input logic dn);
    logic [9:0] r;
    r = p;
    if (up && !dn)      r = (p < PV) ? 10'd0 : p - PV;
    else if (dn && !up) r = (p > PAD_MAX - PV) ? PAD_MAX : p + PV;
    return r;
  endfunction

  // First pixel of the vertical blanking line: everything moves here, never mid-frame.
  assign frame_tick = vid.p_tick && (vid.x == 10'd0) && (vid.y == V_ACTIVE);

  assign pl_d = pad_next(pl_q, btn_up_l, btn_dn_l);
  assign pr_d = pad_next(pr_q, btn_up_r, btn_dn_r);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pl_q <= PAD_INIT;
      pr_q <= PAD_INIT;
    end else if (frame_tick) begin
      pl_q <= pl_d;
      pr_q <= pr_d;
    end
  end

  pong_ball #(
    .BALL_V       (BALL_V),
    .SERVE_FRAMES (SERVE_FRAMES),
    .SCORED_FRAMES(SCORED_FRAMES)
  ) u_ball (
    .clk         (clk),
    .reset       (reset),
    .frame_tick_i(frame_tick),
    .pl_i        (pl_q),
    .pr_i        (pr_q),
    .bx_o        (bx),
    .by_o        (by),
    .hidden_o    (hidden),
    .score_l_o   (score_l),
    .score_r_o   (score_r)
  );

  assign ball_on = !hidden && (vid.x >= bx) && (vid.x < bx + BALL_SIZE)
                   && (vid.y >= by) && (vid.y < by + BALL_SIZE);
  assign padl_on = (vid.x >= PAD_L_X) && (vid.x < PAD_L_X + PAD_W)
                   && (vid.y >= pl_q) && (vid.y < pl_q + PAD_H);
  assign padr_on = (vid.x >= PAD_R_X) && (vid.x < PAD_R_X + PAD_W)
                   && (vid.y >= pr_q) && (vid.y < pr_q + PAD_H);
  assign line_on = ((vid.x == LINE_X0) || (vid.x == LINE_X1)) && !vid.y[4];

  always_comb begin
    rgb_d = COL_BLACK;
    if (!vid.video_on)          rgb_d = COL_BLACK;
    else if (ball_on)           rgb_d = COL_BALL;
    else if (padl_on || padr_on) rgb_d = COL_PAD;
    else if (line_on)           rgb_d = COL_LINE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            rgb_q <= COL_BLACK;
    else if (vid.p_tick)  rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;

endmodule

// File: tb/tb_pong_graphics.sv
// Directed bench for pong_graphics: reset, paddles, serve, bounces, misses, score wrap and pixels.
module tb_pong_graphics;
  import pong_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_up_l, btn_dn_l, btn_up_r, btn_dn_r;
  logic [11:0] rgb;
  logic [3:0]  score_l, score_r;
  int          n_vec = 0;
  int          n_bad = 0;

  pong_graphics_if vid();

  pong_graphics dut (
    .clk     (clk),
    .reset   (reset),
    .vid     (vid),
    .btn_up_l(btn_up_l),
    .btn_dn_l(btn_dn_l),
    .btn_up_r(btn_up_r),
    .btn_dn_r(btn_dn_r),
    .rgb     (rgb),
    .score_l (score_l),
    .score_r (score_r)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic frame(input logic up_l, input logic dn_l, input logic up_r, input logic dn_r);
    @(negedge clk);
    btn_up_l = up_l; btn_dn_l = dn_l; btn_up_r = up_r; btn_dn_r = dn_r;
    vid.p_tick = 1'b1; vid.video_on = 1'b0; vid.x = 10'd0; vid.y = 10'd480;
    @(negedge clk);
    vid.p_tick = 1'b0;
    btn_up_l = 1'b0; btn_dn_l = 1'b0; btn_up_r = 1'b0; btn_dn_r = 1'b0;
  endtask

  task automatic pix(input logic [9:0] px, input logic [9:0] py, input logic von);
    @(negedge clk);
    vid.p_tick = 1'b1; vid.video_on = von; vid.x = px; vid.y = py;
    @(negedge clk);
    vid.p_tick = 1'b0;
  endtask

  // kind: 0 vy turns negative, 1 vx turns negative, 2 vy turns positive, 3 score_r changes, else vx turns positive
  task automatic run_until(input string tag, input int kind, input int limit, input logic dn_l);
    logic [3:0] s0;
    logic       done;
    s0   = score_r;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      frame(1'b0, dn_l, 1'b0, 1'b0);
      case (kind)
        0:       done = dut.u_ball.vy_neg_q;
        1:       done = dut.u_ball.vx_neg_q;
        2:       done = !dut.u_ball.vy_neg_q;
        3:       done = (score_r != s0);
        default: done = !dut.u_ball.vx_neg_q;
      endcase
    end
    check_vec({tag, "_reached"}, 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    btn_up_l = 1'b0; btn_dn_l = 1'b0; btn_up_r = 1'b0; btn_dn_r = 1'b0;
    vid.p_tick = 1'b0; vid.video_on = 1'b0; vid.x = 10'd0; vid.y = 10'd0;
    repeat (3) @(negedge clk);

    check_vec("rst_state",  32'(dut.u_ball.state_q), 32'(ST_SERVE));
    check_vec("rst_bx",     32'(dut.u_ball.bx_q), 32'd316);
    check_vec("rst_by",     32'(dut.u_ball.by_q), 32'd236);
    check_vec("rst_pl",     32'(dut.pl_q), 32'd204);
    check_vec("rst_pr",     32'(dut.pr_q), 32'd204);
    check_vec("rst_vx_neg", 32'(dut.u_ball.vx_neg_q), 32'd0);
    check_vec("rst_vy_neg", 32'(dut.u_ball.vy_neg_q), 32'd0);
    check_vec("rst_scores", {24'd0, score_l, score_r}, 32'd0);
    check_vec("rst_rgb",    32'(rgb), 32'h000);

    // Mid-frame asynchronous reset
    @(negedge clk); reset = 1'b0;
    repeat (5) frame(1'b1, 1'b0, 1'b0, 1'b0);
    check_vec("pre_arst_pl",  32'(dut.pl_q), 32'd184);
    check_vec("pre_arst_cnt", 32'(dut.u_ball.cnt_q), 32'd5);
    @(negedge clk); #2 reset = 1'b1;
    #1;
    check_vec("arst_pl",  32'(dut.pl_q), 32'd204);
    check_vec("arst_cnt", 32'(dut.u_ball.cnt_q), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Pixel mux with ball at (316,236), paddles at 204
    pix(10'd318, 10'd240, 1'b1); check_vec("pix_ball",      32'(rgb), 32'hFFF);
    @(negedge clk); vid.video_on = 1'b0; vid.x = 10'd5; vid.y = 10'd5;
    @(negedge clk); check_vec("pix_hold",      32'(rgb), 32'hFFF);
    pix(10'd318, 10'd240, 1'b0); check_vec("pix_blank",     32'(rgb), 32'h000);
    pix(10'd320, 10'd236, 1'b1); check_vec("pix_ball_line", 32'(rgb), 32'hFFF);
    pix(10'd324, 10'd236, 1'b1); check_vec("pix_ball_edge", 32'(rgb), 32'h000);
    pix(10'd35,  10'd210, 1'b1); check_vec("pix_pad_l",     32'(rgb), 32'h0F0);
    pix(10'd603, 10'd275, 1'b1); check_vec("pix_pad_r_bot", 32'(rgb), 32'h0F0);
    pix(10'd603, 10'd276, 1'b1); check_vec("pix_pad_r_out", 32'(rgb), 32'h000);
    pix(10'd320, 10'd40,  1'b1); check_vec("pix_line_on",   32'(rgb), 32'h888);
    pix(10'd320, 10'd48,  1'b1); check_vec("pix_line_gap",  32'(rgb), 32'h000);

    // Serve delay with paddle clamps running alongside
    frame(1'b1, 1'b0, 1'b0, 1'b1);
    check_vec("pl_up1",   32'(dut.pl_q), 32'd200);
    check_vec("pr_dn1",   32'(dut.pr_q), 32'd208);
    frame(1'b1, 1'b1, 1'b0, 1'b1);
    check_vec("pl_both",  32'(dut.pl_q), 32'd200);
    repeat (57) frame(1'b1, 1'b0, 1'b0, 1'b1);
    check_vec("serve_59", 32'(dut.u_ball.state_q), 32'(ST_SERVE));
    frame(1'b1, 1'b0, 1'b0, 1'b1);
    check_vec("serve_60_state", 32'(dut.u_ball.state_q), 32'(ST_PLAY));
    check_vec("serve_60_vx",    32'(dut.u_ball.vx_neg_q), 32'd0);
    check_vec("pl_clamp0",      32'(dut.pl_q), 32'd0);
    check_vec("pr_clamp408",    32'(dut.pr_q), 32'd408);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_vec("play1_bx", 32'(dut.u_ball.bx_q), 32'd318);
    check_vec("play1_by", 32'(dut.u_ball.by_q), 32'd238);

    // Rally: bottom wall, right paddle, top wall, left miss
    run_until("bot", 0, 300, 1'b0);
    check_vec("bot_by",  32'(dut.u_ball.by_q), 32'd472);
    check_vec("bot_bx",  32'(dut.u_ball.bx_q), 32'd552);
    run_until("padr", 1, 100, 1'b0);
    check_vec("padr_bx", 32'(dut.u_ball.bx_q), 32'd592);
    check_vec("padr_by", 32'(dut.u_ball.by_q), 32'd432);
    run_until("top", 2, 400, 1'b0);
    check_vec("top_by",  32'(dut.u_ball.by_q), 32'd0);
    check_vec("top_bx",  32'(dut.u_ball.bx_q), 32'd158);
    run_until("miss1", 3, 200, 1'b0);
    check_vec("miss1_score_r", 32'(score_r), 32'd1);
    check_vec("miss1_score_l", 32'(score_l), 32'd0);
    check_vec("miss1_state",   32'(dut.u_ball.state_q), 32'(ST_SCORED));
    pix(10'd2, 10'd160, 1'b1); check_vec("pix_hidden", 32'(rgb), 32'h000);

    repeat (29) frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_vec("scored_29", 32'(dut.u_ball.state_q), 32'(ST_SCORED));
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_vec("scored_30_state", 32'(dut.u_ball.state_q), 32'(ST_SERVE));
    check_vec("scored_30_bx",    32'(dut.u_ball.bx_q), 32'd316);
    check_vec("scored_30_by",    32'(dut.u_ball.by_q), 32'd236);
    repeat (60) frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_vec("serve2_state", 32'(dut.u_ball.state_q), 32'(ST_PLAY));
    check_vec("serve2_vx_neg", 32'(dut.u_ball.vx_neg_q), 32'd1);

    // Every left-bound serve misses an idle paddle at 0; score_r runs 2..9 then wraps to 0
    for (int s = 2; s <= 10; s++) begin
      run_until("miss_n", 3, 400, 1'b0);
      check_vec("score_r_n", 32'(score_r), 32'(s % 10));
    end
    check_vec("score_l_final", 32'(score_l), 32'd0);

    // Next serve with the left paddle parked low: returned from the left paddle
    run_until("padl", 4, 400, 1'b1);
    check_vec("padl_bx", 32'(dut.u_ball.bx_q), 32'd40);
    check_vec("padl_by", 32'(dut.u_ball.by_q), 32'd432);
    check_vec("padl_pl", 32'(dut.pl_q), 32'd408);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
